// File: rtl/adder_share_arbiter_pkg.sv
// Shared definitions for the shared-adder arbiter slice: FSM state encoding
// and default widths.
package adder_share_pkg;

    localparam int unsigned DEF_WIDTH   = 32;
    localparam int unsigned DEF_NUM_REQ = 3;

    // 2'd3 is not a legal state; the FSM recovers from it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request after
// last_grant, wrapping around; produces a one-hot grant and its index.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned IDW     = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDW-1:0]     gnt_idx
);

    int unsigned lg;
    logic        found;

    // Two passes: indices above last_grant first, then wrap to 0..last_grant.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        lg      = 32'(last_grant);
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i > lg)) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i] && (i <= lg)) begin
                found   = 1'b1;
                gnt[i]  = 1'b1;
                gnt_idx = IDW'(i);
            end
        end
        if (!en) begin
            gnt     = '0;
            gnt_idx = '0;
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one external combinational adder among NUM_REQ requesters with
// round-robin arbitration, one operation in flight and a registered response.
module adder_share_arbiter
    import adder_share_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned IDW     = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    output logic                     add_cin,
    input  logic [WIDTH-1:0]         add_sum,
    input  logic                     add_cout,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [IDW-1:0]           rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_cout,
    output logic                     rsp_ovf
);

    state_e             state_q, state_d;
    logic [IDW-1:0]     last_q, last_d;
    logic [WIDTH-1:0]   op_a_q, op_a_d, op_b_q, op_b_d;
    logic               op_cin_q, op_cin_d;
    logic [IDW-1:0]     op_id_q, op_id_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0]   rsp_sum_q, rsp_sum_d;
    logic               rsp_cout_q, rsp_cout_d;
    logic               rsp_ovf_q, rsp_ovf_d;

    logic [NUM_REQ-1:0] gnt;
    logic [IDW-1:0]     gnt_idx;
    logic [WIDTH-1:0]   sel_a, sel_b;
    logic               sel_sub;

    // rst_n gates the grant so req_ready is zero while reset is held.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_q),
        .en         ((state_q == ST_IDLE) && rst_n),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx)
    );

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_sub = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sel_a   = sel_a | ({WIDTH{gnt[i]}} & req_a[i*WIDTH +: WIDTH]);
            sel_b   = sel_b | ({WIDTH{gnt[i]}} & req_b[i*WIDTH +: WIDTH]);
            sel_sub = sel_sub | (gnt[i] & req_sub[i]);
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_cin_d   = op_cin_q;
        op_id_d    = op_id_q;
        rsp_id_d   = rsp_id_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        rsp_ovf_d  = rsp_ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    op_a_d   = sel_a;
                    op_b_d   = sel_sub ? ~sel_b : sel_b;
                    op_cin_d = sel_sub;
                    op_id_d  = gnt_idx;
                    last_d   = gnt_idx;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                rsp_sum_d  = add_sum;
                rsp_cout_d = add_cout;
                rsp_id_d   = op_id_q;
                rsp_ovf_d  = (op_a_q[WIDTH-1] == op_b_q[WIDTH-1]) &&
                             (add_sum[WIDTH-1] != op_a_q[WIDTH-1]);
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            last_q     <= IDW'(NUM_REQ - 1);
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_cin_q   <= 1'b0;
            op_id_q    <= '0;
            rsp_id_q   <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_cin_q   <= op_cin_d;
            op_id_q    <= op_id_d;
            rsp_id_q   <= rsp_id_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_ovf_q  <= rsp_ovf_d;
        end
    end

    assign req_ready = gnt;
    assign add_a     = op_a_q;
    assign add_b     = op_b_q;
    assign add_cin   = op_cin_q;
    assign rsp_valid = (state_q == ST_DONE);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter with a behavioural
// 32-bit adder attached to the add_* ports.
module tb_adder_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req_valid = '0;
    logic [2:0]  req_ready;
    logic [95:0] req_a = '0;
    logic [95:0] req_b = '0;
    logic [2:0]  req_sub = '0;
    logic [31:0] add_a, add_b, add_sum;
    logic        add_cin, add_cout;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_sum;
    logic        rsp_cout, rsp_ovf;
    logic [32:0] add_res;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign add_res  = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};
    assign add_sum  = add_res[31:0];
    assign add_cout = add_res[32];

    adder_share_arbiter #(
        .NUM_REQ (3),
        .WIDTH   (32),
        .IDW     (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One full transaction with rsp_ready held high; checks EXEC drive and DONE result.
    task automatic do_op(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] exp_b,
                         input logic [31:0] exp_sum, input logic exp_cout,
                         input logic exp_ovf, input string name);
        int n;
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_sub[id]        = sub;
        req_valid[id]      = 1'b1;
        rsp_ready          = 1'b1;
        #1;
        n = 0;
        while (req_ready[id] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (req_ready !== 3'(1 << id)) begin
            fails++;
            $display("FAIL %s grant: req_ready=%b required=%b", name, req_ready, 3'(1 << id));
            req_valid[id] = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid[id] = 1'b0;
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 3'b000) begin
            fails++;
            $display("FAIL %s exec_flags: rsp_valid=%b req_ready=%b required 0/000", name, rsp_valid, req_ready);
        end
        tests++;
        if (add_a !== a || add_b !== exp_b || add_cin !== sub) begin
            fails++;
            $display("FAIL %s exec_drive: a=%h b=%h cin=%b required a=%h b=%h cin=%b",
                     name, add_a, add_b, add_cin, a, exp_b, sub);
        end
        @(posedge clk); #1;
        tests++;
        if (rsp_valid !== 1'b1) begin
            fails++;
            $display("FAIL %s latency: rsp_valid=%b required 1", name, rsp_valid);
        end
        tests++;
        if (rsp_sum !== exp_sum || rsp_cout !== exp_cout || rsp_ovf !== exp_ovf || rsp_id !== 2'(id)) begin
            fails++;
            $display("FAIL %s result: sum=%h cout=%b ovf=%b id=%0d required sum=%h cout=%b ovf=%b id=%0d",
                     name, rsp_sum, rsp_cout, rsp_ovf, rsp_id, exp_sum, exp_cout, exp_ovf, id);
        end
        @(posedge clk); #1;
        tests++;
        if (rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s rsp_drop: rsp_valid=%b required 0", name, rsp_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if (req_ready !== 3'b000 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 ||
            rsp_sum !== 32'd0 || rsp_cout !== 1'b0 || rsp_ovf !== 1'b0 ||
            add_a !== 32'd0 || add_b !== 32'd0 || add_cin !== 1'b0) begin
            fails++;
            $display("FAIL reset_values: req_ready=%b rsp_valid=%b id=%0d sum=%h cout=%b ovf=%b a=%h b=%h cin=%b required all zero",
                     req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf, add_a, add_b, add_cin);
        end
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (req_ready !== 3'b000 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_no_req: req_ready=%b rsp_valid=%b required 000/0", req_ready, rsp_valid);
        end
    endtask

    task automatic test_add();
        do_op(0, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'h0000_0007, 32'h0000_000C, 1'b0, 1'b0, "add_5_7");
    endtask

    task automatic test_sub();
        do_op(1, 32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_5_7");
        do_op(1, 32'h0000_0007, 32'h0000_0005, 1'b1, 32'hFFFF_FFFA, 32'h0000_0002, 1'b1, 1'b0, "sub_7_5");
    endtask

    task automatic test_overflow();
        do_op(2, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1, "ovf_pos");
        do_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, "wrap");
        do_op(1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 1'b1, 1'b1, "ovf_neg");
    endtask

    task automatic test_round_robin();
        int order [6] = '{0, 1, 2, 0, 1, 2};
        int n;
        pulse_reset();
        req_sub   = '0;
        req_valid = 3'b111;
        rsp_ready = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            while (req_ready === 3'b000 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            tests++;
            if (req_ready !== 3'(1 << order[k])) begin
                fails++;
                $display("FAIL rr_grant_%0d: req_ready=%b required=%b", k, req_ready, 3'(1 << order[k]));
            end
            @(posedge clk); #1;
            tests++;
            if (req_ready !== 3'b000) begin
                fails++;
                $display("FAIL rr_exec_ready_%0d: req_ready=%b required 000", k, req_ready);
            end
            @(posedge clk); #1;
            tests++;
            if (req_ready !== 3'b000 || rsp_valid !== 1'b1 || rsp_id !== 2'(order[k])) begin
                fails++;
                $display("FAIL rr_done_%0d: req_ready=%b rsp_valid=%b id=%0d required 000/1/%0d",
                         k, req_ready, rsp_valid, rsp_id, order[k]);
            end
            @(posedge clk); #1;
        end
        req_valid = 3'b000;
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        req_a[31:0]  = 32'h0000_0010;
        req_b[31:0]  = 32'h0000_0020;
        req_a[63:32] = 32'h0000_0001;
        req_b[63:32] = 32'h0000_0002;
        req_sub      = '0;
        rsp_ready    = 1'b0;
        req_valid    = 3'b011;
        #1;
        tests++;
        if (req_ready !== 3'b001) begin
            fails++;
            $display("FAIL bp_grant0: req_ready=%b required 001", req_ready);
        end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            tests++;
            if (rsp_valid !== 1'b1 || rsp_sum !== 32'h0000_0030 || rsp_id !== 2'd0 ||
                rsp_cout !== 1'b0 || req_ready !== 3'b000) begin
                fails++;
                $display("FAIL bp_hold_%0d: rsp_valid=%b sum=%h id=%0d cout=%b req_ready=%b required 1/00000030/0/0/000",
                         c, rsp_valid, rsp_sum, rsp_id, rsp_cout, req_ready);
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 3'b010) begin
            fails++;
            $display("FAIL bp_release: rsp_valid=%b req_ready=%b required 0/010", rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        req_valid = 3'b000;
        @(posedge clk); #1;
        tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_sum !== 32'h0000_0003) begin
            fails++;
            $display("FAIL bp_next: rsp_valid=%b id=%0d sum=%h required 1/1/00000003", rsp_valid, rsp_id, rsp_sum);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_op();
        int n;
        req_a[95:64] = 32'h0000_1234;
        req_b[95:64] = 32'h0000_0001;
        req_sub      = '0;
        rsp_ready    = 1'b1;
        req_valid    = 3'b100;
        #1;
        n = 0;
        while (req_ready[2] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        tests++;
        if (add_a !== 32'h0000_1234 || rsp_valid !== 1'b0) begin
            fails++;
            $display("FAIL mid_exec: add_a=%h rsp_valid=%b required 00001234/0", add_a, rsp_valid);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (add_a !== 32'd0 || add_b !== 32'd0 || add_cin !== 1'b0 || rsp_valid !== 1'b0 ||
            req_ready !== 3'b000 || rsp_sum !== 32'd0 || rsp_id !== 2'd0) begin
            fails++;
            $display("FAIL mid_async_reset: a=%h b=%h cin=%b rsp_valid=%b req_ready=%b sum=%h id=%0d required all zero",
                     add_a, add_b, add_cin, rsp_valid, req_ready, rsp_sum, rsp_id);
        end
        req_valid = 3'b000;
        @(posedge clk); #1;
        @(posedge clk); #3;
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            tests++;
            if (rsp_valid !== 1'b0) begin
                fails++;
                $display("FAIL mid_no_rsp_%0d: rsp_valid=%b required 0", c, rsp_valid);
            end
        end
        req_valid = 3'b101;
        #1;
        tests++;
        if (req_ready !== 3'b001) begin
            fails++;
            $display("FAIL mid_first_grant: req_ready=%b required 001", req_ready);
        end
        req_valid = 3'b000;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_overflow();
        test_round_robin();
        test_backpressure();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
